// File: rtl/overture_sequencer.sv
// Overture instruction sequencer: fetches one byte per instruction, decodes
// IMMEDIATE / CALCULATE / COPY / CONDITION and drives the register file, ALU and
// I/O port handshakes. Every strobe is a registered output.
// Optional I/O watchdog: define OVERTURE_SEQ_WATCHDOG_EN to enable it.
module overture_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'd0,
  parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] pc,
  output logic       fetch_req,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  input  logic [7:0] jump_addr,
  input  logic       cond_true,
  output logic [2:0] src_sel,
  output logic [2:0] dst_sel,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       wr_data_sel,
  output logic       alu_en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_from_hold,
  output logic       busy,
  output logic       wdog_err
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StInWait, StOutWait} state_e;

  localparam logic [1:0] ModeImm  = 2'b00;
  localparam logic [1:0] ModeCalc = 2'b01;
  localparam logic [1:0] ModeCopy = 2'b10;
  localparam logic [1:0] ModeCond = 2'b11;
  localparam logic [2:0] PortReg  = 3'd6;

  state_e     state_q;
  logic [7:0] pc_q, ir_q, hold_q, wr_data_q;
  logic [2:0] src_sel_q, dst_sel_q;
  logic       fetch_req_q, wr_en_q, wr_data_sel_q, alu_en_q;
  logic       in_ready_q, out_valid_q, out_from_hold_q, busy_q;

  logic [1:0] ir_mode;
  logic [2:0] ir_src, ir_dst;
  logic       to_in_wait, to_out_wait, done, wdog_abort;
  logic [7:0] pc_inc, pc_next;

  assign ir_mode = ir_q[7:6];
  assign ir_src  = ir_q[5:3];
  assign ir_dst  = ir_q[2:0];
  assign pc_inc  = pc_q + 8'd1;

  // Decode of the latched instruction: which EXEC cycles hand off to a port
  // wait state, and when the current instruction completes.
  always_comb begin
    to_in_wait  = 1'b0;
    to_out_wait = 1'b0;
    done        = 1'b0;
    pc_next     = pc_inc;
    if (ir_mode == ModeCopy && ir_src == PortReg) begin
      to_in_wait = 1'b1;
    end else if (ir_mode == ModeCopy && ir_dst == PortReg && ir_src < PortReg) begin
      to_out_wait = 1'b1;
    end
    unique case (state_q)
      StExec: begin
        done = !to_in_wait && !to_out_wait;
        if (ir_mode == ModeCond && cond_true) begin
          pc_next = jump_addr;
        end
      end
      StInWait:  done = in_valid ? (ir_dst != PortReg) : wdog_abort;
      StOutWait: done = out_ready || wdog_abort;
      default:   done = 1'b0;
    endcase
  end

`ifdef OVERTURE_SEQ_WATCHDOG_EN
  logic [7:0] wdog_cnt_q;
  logic       wdog_err_q;
  logic       wait_cycle;

  // A wait cycle is one spent in a port state without the handshake completing.
  assign wait_cycle = (state_q == StInWait && !in_valid) ||
                      (state_q == StOutWait && !out_ready);
  assign wdog_abort = wait_cycle && (wdog_cnt_q == WDOG_LIMIT - 8'd1);
  assign wdog_err   = wdog_err_q;

  // Wait-cycle counter; zero outside wait cycles so each wait state starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= 8'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wait_cycle ? wdog_cnt_q + 8'd1 : 8'd0;
      if (wdog_abort) begin
        wdog_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_abort  = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  // Sequencer FSM with registered strobes, set on entry to the cycle they mark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      pc_q            <= RESET_PC;
      ir_q            <= 8'd0;
      hold_q          <= 8'd0;
      wr_data_q       <= 8'd0;
      src_sel_q       <= 3'd0;
      dst_sel_q       <= 3'd0;
      fetch_req_q     <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_data_sel_q   <= 1'b0;
      alu_en_q        <= 1'b0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_from_hold_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q     <= StFetch;
            fetch_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StFetch: begin
          if (instr_valid) begin
            ir_q        <= instr;
            state_q     <= StExec;
            fetch_req_q <= 1'b0;
            unique case (instr[7:6])
              ModeImm: begin
                wr_en_q       <= 1'b1;
                dst_sel_q     <= 3'd0;
                wr_data_sel_q <= 1'b1;
                wr_data_q     <= {2'b00, instr[5:0]};
              end
              ModeCalc: begin
                alu_en_q  <= 1'b1;
                src_sel_q <= instr[2:0];
              end
              ModeCopy: begin
                if (instr[5:3] < PortReg && instr[2:0] < PortReg) begin
                  wr_en_q       <= 1'b1;
                  src_sel_q     <= instr[5:3];
                  dst_sel_q     <= instr[2:0];
                  wr_data_sel_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        StExec: begin
          if (to_in_wait) begin
            state_q    <= StInWait;
            in_ready_q <= 1'b1;
          end else if (to_out_wait) begin
            state_q         <= StOutWait;
            out_valid_q     <= 1'b1;
            out_from_hold_q <= 1'b0;
            src_sel_q       <= ir_src;
          end
        end
        StInWait: begin
          if (in_valid) begin
            hold_q     <= in_data;
            in_ready_q <= 1'b0;
            if (ir_dst == PortReg) begin
              state_q         <= StOutWait;
              out_valid_q     <= 1'b1;
              out_from_hold_q <= 1'b1;
              src_sel_q       <= ir_src;
            end else if (ir_dst < PortReg) begin
              wr_en_q       <= 1'b1;
              wr_data_q     <= in_data;
              wr_data_sel_q <= 1'b1;
              dst_sel_q     <= ir_dst;
            end
          end else if (wdog_abort) begin
            in_ready_q <= 1'b0;
          end
        end
        StOutWait: begin
          if (out_ready || wdog_abort) begin
            out_valid_q     <= 1'b0;
            out_from_hold_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
      // run is only looked at when an instruction retires.
      if (done) begin
        pc_q        <= pc_next;
        state_q     <= run ? StFetch : StIdle;
        fetch_req_q <= run;
        busy_q      <= run;
      end
    end
  end

  assign pc            = pc_q;
  assign fetch_req     = fetch_req_q;
  assign src_sel       = src_sel_q;
  assign dst_sel       = dst_sel_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign wr_data_sel   = wr_data_sel_q;
  assign alu_en        = alu_en_q;
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = hold_q;
  assign out_from_hold = out_from_hold_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_overture_sequencer.sv
// Directed bench for overture_sequencer: register writes and output-port
// transfers are checked against scoreboard queues; pc and strobes directly.
module tb_overture_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, instr_valid, cond_true, in_valid, out_ready;
  logic [7:0] instr, jump_addr, in_data;
  logic [7:0] pc, wr_data, out_data;
  logic [2:0] src_sel, dst_sel;
  logic       fetch_req, wr_en, wr_data_sel, alu_en, in_ready, out_valid;
  logic       out_from_hold, busy, wdog_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [2:0] dst;
    logic       sel;
    logic [7:0] data;
  } wr_t;
  typedef struct packed {
    logic       from_hold;
    logic [7:0] data;
  } out_t;

  wr_t  exp_wr[$];
  out_t exp_out[$];
  wr_t  w;
  out_t o;

  always #5 clk = ~clk;

  overture_sequencer #(
    .RESET_PC   (8'h00),
    .WDOG_LIMIT (8'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .pc            (pc),
    .fetch_req     (fetch_req),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .jump_addr     (jump_addr),
    .cond_true     (cond_true),
    .src_sel       (src_sel),
    .dst_sel       (dst_sel),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_data_sel   (wr_data_sel),
    .alu_en        (alu_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_from_hold (out_from_hold),
    .busy          (busy),
    .wdog_err      (wdog_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction in FETCH; returns during its EXEC cycle.
  task automatic fetch(input logic [7:0] i);
    instr       = i;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  // Scoreboard: every write strobe and every accepted output transfer pops one entry.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        chk("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("wr_dst", dst_sel, w.dst);
          chk("wr_sel", wr_data_sel, w.sel);
          if (w.sel) chk("wr_data", wr_data, w.data);
        end
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_out.size() != 0), 1);
        if (exp_out.size() != 0) begin
          o = exp_out.pop_front();
          chk("out_from_hold", out_from_hold, o.from_hold);
          if (o.from_hold) chk("out_data", out_data, o.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; run = 1'b0; instr = 8'h00; instr_valid = 1'b0; jump_addr = 8'h00;
    cond_true = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3;
    chk("rst_pc", pc, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wdog_err", wdog_err, 0);
    step(2);
    rst = 1'b1;
    step();
    chk("idle_hold", busy, 0);

    // Immediate 0x05 presented at once
    run = 1'b1; instr = 8'h05; instr_valid = 1'b1;
    exp_wr.push_back('{dst: 3'd0, sel: 1'b1, data: 8'h05});
    step();
    chk("first_fetch_req", fetch_req, 1);
    chk("first_fetch_busy", busy, 1);
    step();
    instr_valid = 1'b0;
    chk("imm_wr_en", wr_en, 1);
    chk("imm_wr_data", wr_data, 8'h05);
    chk("imm_dst", dst_sel, 0);
    chk("imm_pc_exec", pc, 8'h00);
    step();
    chk("imm_pc", pc, 8'h01);
    chk("imm_refetch", fetch_req, 1);
    step();
    chk("fetch_stall", fetch_req, 1);

    // Copy in -> r0, data after three wait cycles
    exp_wr.push_back('{dst: 3'd0, sel: 1'b1, data: 8'h5A});
    fetch(8'hB0);
    chk("in_exec_no_wr", wr_en, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("in_ready_hold", in_ready, 1);
      if (k == 3) begin
        in_valid = 1'b1;
        in_data  = 8'h5A;
      end
      step();
    end
    in_valid = 1'b0;
    chk("in_ready_drop", in_ready, 0);
    chk("in_wr_en", wr_en, 1);
    chk("in_pc", pc, 8'h02);

    // Copy in -> out with a stalled consumer
    fetch(8'hB6);
    step();
    chk("io_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h33;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      chk("out_valid_hold", out_valid, 1);
      chk("out_data_stable", out_data, 8'h33);
      chk("out_hold_sel", out_from_hold, 1);
      step();
    end
    exp_out.push_back('{from_hold: 1'b1, data: 8'h33});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("out_pc", pc, 8'h03);

    // Register copy r1 -> r2
    exp_wr.push_back('{dst: 3'd2, sel: 1'b0, data: 8'h00});
    fetch(8'h8A);
    chk("copy_wr_en", wr_en, 1);
    chk("copy_src", src_sel, 3'd1);
    step();
    chk("copy_pc", pc, 8'h04);

    // Calculate with src select 3
    fetch(8'h43);
    chk("calc_alu_en", alu_en, 1);
    chk("calc_src", src_sel, 3'd3);
    chk("calc_no_wr", wr_en, 0);
    step();
    chk("calc_alu_drop", alu_en, 0);
    chk("calc_pc", pc, 8'h05);

    // Copy from r7: no strobe
    fetch(8'hB8);
    chk("r7_no_wr", wr_en, 0);
    step();
    chk("r7_pc", pc, 8'h06);

    // Register r1 -> output port
    fetch(8'h8E);
    step();
    chk("rout_valid", out_valid, 1);
    chk("rout_from_hold", out_from_hold, 0);
    chk("rout_src", src_sel, 3'd1);
    exp_out.push_back('{from_hold: 1'b0, data: 8'h00});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rout_pc", pc, 8'h07);

    // Condition: jump to 0xFF, then wrap, then jump to 0x10
    jump_addr = 8'hFF; cond_true = 1'b1;
    fetch(8'hC0);
    step();
    chk("cond_jump_ff", pc, 8'hFF);
    cond_true = 1'b0;
    fetch(8'hC0);
    step();
    chk("cond_wrap", pc, 8'h00);
    cond_true = 1'b1; jump_addr = 8'h10;
    fetch(8'hC0);
    step();
    chk("cond_jump_10", pc, 8'h10);
    cond_true = 1'b0;

    // Dropping run mid-instruction returns to IDLE only at completion
    exp_wr.push_back('{dst: 3'd0, sel: 1'b1, data: 8'h01});
    fetch(8'h01);
    run = 1'b0;
    chk("run_low_busy_exec", busy, 1);
    step();
    chk("run_low_idle", busy, 0);
    chk("run_low_pc", pc, 8'h11);
    step();
    chk("run_low_no_fetch", fetch_req, 0);
    run = 1'b1;
    step();
    chk("run_restart", fetch_req, 1);

    // Input port that never responds
    fetch(8'hB0);
    step();
`ifdef OVERTURE_SEQ_WATCHDOG_EN
    begin
      int n = 0;
      while (in_ready && n < 20) begin
        n++;
        step();
      end
      chk("wdog_wait_cycles", n, 4);
      chk("wdog_err_set", wdog_err, 1);
      chk("wdog_pc", pc, 8'h12);
    end
`else
    step(30);
    chk("wait_forever", in_ready, 1);
    chk("no_wdog_err", wdog_err, 0);
    exp_wr.push_back('{dst: 3'd0, sel: 1'b1, data: 8'hA5});
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("late_in_pc", pc, 8'h12);
`endif

    // Asynchronous reset during OUT_WAIT
    fetch(8'h8E);
    step();
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_busy", busy, 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_fetch", fetch_req, 1);
    chk("post_rst_pc", pc, 8'h00);

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("out_queue_drained", exp_out.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
